// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-master arbiter for a single synchronous-read data RAM port.
//
// Purpose:
//   Shares one RAM port between the CPU data port (m0) and a second bus master
//   (m1: loader/DMA). Grant is combinational, round-robin on ties, with a
//   bounded burst lock so one master can hold the port for at most MAX_BURST
//   consecutive transfers while the other is waiting. Read data comes back to
//   the issuing master one cycle after acceptance (RAM read latency).
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   mN_valid/ready             request handshake (transfer = valid & ready)
//   mN_write/addr/wdata        request payload
//   mN_rvalid/rdata            read response, one cycle after a read transfer
//   mem_en/write/addr/wdata    RAM port, muxed from the granted master
//   mem_rdata                  RAM read data, valid the cycle after a read

// Per-master response steering: one instance per master.
module mem_arbiter_rsp #(
  parameter int DW = 32,
  parameter bit ID = 1'b0
) (
  input  logic          i_pend,
  input  logic          i_who,
  input  logic [DW-1:0] i_rdata,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);
  assign o_rvalid = i_pend & (i_who == ID);
  // Data is broadcast; only the owner's rvalid qualifies it.
  assign o_rdata  = i_rdata;
endmodule

module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int NM = 2;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          r_last;     // master of most recent transfer
  logic [CW-1:0] r_cnt;      // run length of r_last; 0 means last cycle was idle
  logic          r_rd_pend;
  logic          r_rd_who;

  logic [NM-1:0]          w_req_v;
  req_t [NM-1:0]          w_req;
  logic                   w_lock;
  logic                   w_gnt_vld;
  logic                   w_gnt;
  logic [CW-1:0]          w_cnt_inc;
  logic [NM-1:0]          w_rvalid;
  logic [NM-1:0][DW-1:0]  w_rdata;

  // Requests are masked while in reset so ready/mem outputs stay low.
  assign w_req_v  = {m1_valid, m0_valid} & {NM{reset}};
  assign w_req[0] = '{write: m0_write, addr: m0_addr, wdata: m0_wdata};
  assign w_req[1] = '{write: m1_write, addr: m1_addr, wdata: m1_wdata};

  // r_cnt != 0 implies the previous cycle carried a transfer by r_last,
  // because an idle cycle clears the counter.
  assign w_lock = (r_cnt != '0) && (r_cnt < CMAX) && w_req_v[r_last];

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (w_lock) begin
      w_gnt_vld = 1'b1;
      w_gnt     = r_last;
    end else if (&w_req_v) begin
      w_gnt_vld = 1'b1;
      w_gnt     = ~r_last;
    end else if (w_req_v[0]) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b0;
    end else if (w_req_v[1]) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b1;
    end
  end

  assign m0_ready  = w_gnt_vld & ~w_gnt;
  assign m1_ready  = w_gnt_vld &  w_gnt;

  assign mem_en    = w_gnt_vld;
  assign mem_write = w_gnt_vld & w_req[w_gnt].write;
  assign mem_addr  = w_gnt_vld ? w_req[w_gnt].addr  : '0;
  assign mem_wdata = w_gnt_vld ? w_req[w_gnt].wdata : '0;

  assign w_cnt_inc = (r_cnt == CMAX) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last    <= 1'b1;     // m0 wins the first tie
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_who  <= 1'b0;
    end else if (w_gnt_vld) begin
      r_last    <= w_gnt;
      r_cnt     <= ((w_gnt == r_last) && (r_cnt != '0)) ? w_cnt_inc : CW'(1);
      r_rd_pend <= ~w_req[w_gnt].write;
      r_rd_who  <= w_gnt;
    end else begin
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
    end
  end

  for (genvar g = 0; g < NM; g++) begin : g_rsp
    mem_arbiter_rsp #(.DW(DW), .ID(g[0])) u_rsp (
      .i_pend   (r_rd_pend),
      .i_who    (r_rd_who),
      .i_rdata  (mem_rdata),
      .o_rvalid (w_rvalid[g]),
      .o_rdata  (w_rdata[g])
    );
  end

  assign m0_rvalid = w_rvalid[0];
  assign m1_rvalid = w_rvalid[1];
  assign m0_rdata  = w_rdata[0];
  assign m1_rdata  = w_rdata[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed per-cycle vectors with hand-computed
// grants; read responses are checked by a scoreboard monitor.
module tb_mem_arbiter;
  logic        clk, reset;
  logic        m0_valid, m0_ready, m0_write, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_valid, m1_ready, m1_write, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_en, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct { bit who; logic [31:0] d; } exp_t;
  exp_t q[$];

  logic [31:0] ram [64];

  mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM; preloaded while reset is asserted.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4] <= 32'hA; ram[5] <= 32'hB; ram[6] <= 32'hC;
    end else if (mem_en) begin
      if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;
      else           mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard whenever any rvalid is seen.
  always @(negedge clk) begin
    if (m0_rvalid && m1_rvalid) begin
      checks++; errors++;
      $display("FAIL rsp_both: got rvalid=11 want one-hot (t=%0t)", $time);
    end else if (m0_rvalid || m1_rvalid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_spurious: got rvalid m0=%0b m1=%0b want none (t=%0t)",
                 m0_rvalid, m1_rvalid, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_who", {31'b0, m1_rvalid}, {31'b0, e.who});
        chk("rsp_data", m1_rvalid ? m1_rdata : m0_rdata, e.d);
      end
    end
  end

  // One bus cycle: drive, check combinational grant at negedge, queue the
  // expected read response, advance to just after the next rising edge.
  // eg: expected grant (-1 none, 0 m0, 1 m1); ed: expected read data.
  task automatic cyc(input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                     input int eg, input logic [31:0] ed, input bit rsp, input string nm);
    bit          ew;
    logic [31:0] ea, edd;
    m0_valid = v0; m0_write = w0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_write = w1; m1_addr = a1; m1_wdata = d1;
    ew  = (eg == 0) ? w0 : (eg == 1) ? w1 : 1'b0;
    ea  = (eg == 0) ? a0 : (eg == 1) ? a1 : 32'h0;
    edd = (eg == 0) ? d0 : (eg == 1) ? d1 : 32'h0;
    @(negedge clk);
    chk({nm, ".m0_ready"}, {31'b0, m0_ready}, {31'b0, eg == 0});
    chk({nm, ".m1_ready"}, {31'b0, m1_ready}, {31'b0, eg == 1});
    chk({nm, ".mem_en"}, {31'b0, mem_en}, {31'b0, eg >= 0});
    chk({nm, ".mem_write"}, {31'b0, mem_write}, {31'b0, ew});
    chk({nm, ".mem_addr"}, mem_addr, ea);
    chk({nm, ".mem_wdata"}, mem_wdata, edd);
    if (eg >= 0 && !ew && rsp) q.push_back('{who: (eg == 1), d: ed});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, nm);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_valid = 0; m1_valid = 0;
    @(negedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with both masters requesting writes.
    reset = 1'b0;
    m0_valid = 1; m0_write = 1; m0_addr = 32'h10; m0_wdata = 32'h1;
    m1_valid = 1; m1_write = 1; m1_addr = 32'h14; m1_wdata = 32'h2;
    @(negedge clk);
    chk("rst.m0_ready", {31'b0, m0_ready}, 32'h0);
    chk("rst.m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("rst.m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    chk("rst.m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
    chk("rst.mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst.mem_write", {31'b0, mem_write}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // First tie after reset goes to m0.
    cyc(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0, 32'hA, 1, "first_tie");
    idle("idle0");

    // m0 back-to-back reads.
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'hA, 1, "b2b0");
    cyc(1, 0, 32'h14, 0, 0, 0, 0, 0, 0, 32'hB, 1, "b2b1");
    cyc(1, 0, 32'h18, 0, 0, 0, 0, 0, 0, 32'hC, 1, "b2b2");
    idle("idle1");

    // Continuous contention from reset: 4 x m0, 4 x m1, repeated.
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, (i / 4) % 2,
          ((i / 4) % 2) ? 32'hB : 32'hA, 1, "burst");
    idle("idle2");

    // Write then read-after-write from the other master.
    cyc(1, 1, 32'h20, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, "wr");
    cyc(0, 0, 0, 0, 1, 0, 32'h20, 0, 1, 32'hDEADBEEF, 1, "raw");
    idle("idle3");

    // m1 builds cnt=2, idles a cycle, then tie -> lock broken, m0 wins.
    cyc(0, 0, 0, 0, 1, 0, 32'h14, 0, 1, 32'hB, 1, "m1run0");
    cyc(0, 0, 0, 0, 1, 0, 32'h14, 0, 1, 32'hB, 1, "m1run1");
    idle("gap");
    cyc(1, 0, 32'h18, 0, 1, 0, 32'h14, 0, 0, 32'hC, 1, "lockbrk");
    cyc(1, 0, 32'h18, 0, 1, 0, 32'h14, 0, 0, 32'hC, 1, "lockhold");
    idle("idle4");

    // Lone requester keeps the grant past MAX_BURST; m1 then gets in.
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 32'h30 + 4 * i, 32'h100 + i, 0, 0, 0, 0, 0, 0, 0, "lone");
    cyc(1, 0, 32'h30, 0, 1, 0, 32'h38, 0, 1, 32'h102, 1, "after_lone");
    idle("idle5");

    // Reset asserted the cycle after an m1 read: response is dropped.
    cyc(0, 0, 0, 0, 1, 0, 32'h14, 0, 1, 0, 0, "rd_pre_rst");
    reset = 1'b0;
    @(negedge clk);
    chk("midrst.m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
    chk("midrst.m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("midrst.mem_en", {31'b0, mem_en}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle("post_rst");
    cyc(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0, 32'hA, 1, "post_rst_tie");
    idle("idle6");
    idle("idle7");

    chk("scoreboard_empty", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
